// File: rtl/control_sequencer.sv
// Multicycle sequencing FSM for the JZJCoreF datapath: picks per-instruction cycle count,
// handles memory latency and memoryReady stalls, latches halt causes and counts retirements.

package control_sequencer_pkg;
    typedef enum logic [1:0] {
        NOP           = 2'd0,
        LOAD          = 2'd1,
        STORE_PRELOAD = 2'd2,
        STORE         = 2'd3
    } MemoryMode_t;

    typedef enum logic {
        CURRENT_PC = 1'b0,
        NEXT_PC    = 1'b1
    } InstructionAddressSource_t;
endpackage

module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned LOAD_LATENCY          = 1,
    parameter int unsigned STORE_PRELOAD_LATENCY = 1,
    parameter bit          SW_SINGLE_CYCLE       = 1'b1,
    parameter int unsigned WAIT_WIDTH            = 4,
    parameter int unsigned RETIRE_WIDTH          = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [6:0]                opcode,
    input  logic [2:0]                funct3,
    input  logic                      memoryReady,
    input  logic                      programCounterMisaligned,
    input  logic                      memoryUnalignedAccess,
    output logic                      rdWriteEnable,
    output MemoryMode_t               memoryMode,
    output logic                      programCounterWriteEnable,
    output InstructionAddressSource_t instructionAddressSource,
    output logic                      halted,
    output logic [3:0]                haltCause,
    output logic [RETIRE_WIDTH-1:0]   retiredCount
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [WAIT_WIDTH-1:0] LOAD_WAIT  = WAIT_WIDTH'(LOAD_LATENCY - 1);
    localparam logic [WAIT_WIDTH-1:0] STORE_WAIT = WAIT_WIDTH'(STORE_PRELOAD_LATENCY - 1);

    typedef enum logic [3:0] {
        S_INITIAL_FETCH = 4'b0001,
        S_FETCH_EXECUTE = 4'b0010,
        S_EXECUTE       = 4'b0100,
        S_HALT          = 4'b1000
    } state_t;

    state_t                  state, next_state;
    logic [WAIT_WIDTH-1:0]   wait_count, next_wait;
    logic                    capture_halt;

    logic is_load, is_store, is_system, is_multicycle;
    logic opcode_valid, writes_rd, halt_request;
    logic [3:0] cause_bits;
    logic [WAIT_WIDTH-1:0] entry_wait;

    always_comb begin
        opcode_valid = 1'b0;
        writes_rd    = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM: begin
                opcode_valid = 1'b1;
                writes_rd    = 1'b1;
            end
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_MISC_MEM, OPC_SYSTEM: opcode_valid = 1'b1;
            default: ;
        endcase
    end

    assign is_load       = (opcode == OPC_LOAD);
    assign is_store      = (opcode == OPC_STORE);
    assign is_system     = (opcode == OPC_SYSTEM);
    // sw is the only store that can skip the preload pass, and only when configured to.
    assign is_multicycle = is_load | (is_store & ((funct3 != 3'b010) | !SW_SINGLE_CYCLE));
    assign entry_wait    = is_load ? LOAD_WAIT : STORE_WAIT;
    assign cause_bits    = {programCounterMisaligned, memoryUnalignedAccess, !opcode_valid, is_system};
    assign halt_request  = |cause_bits;

    always_comb begin
        rdWriteEnable             = 1'b0;
        memoryMode                = NOP;
        programCounterWriteEnable = 1'b0;
        instructionAddressSource  = CURRENT_PC;
        next_state                = state;
        next_wait                 = wait_count;
        capture_halt              = 1'b0;

        unique case (state)
            S_INITIAL_FETCH: begin
                next_state = is_multicycle ? S_EXECUTE : S_FETCH_EXECUTE;
                next_wait  = entry_wait;
            end
            S_EXECUTE: begin
                if (halt_request) begin
                    next_state   = S_HALT;
                    capture_halt = 1'b1;
                end else begin
                    memoryMode = is_load ? LOAD : STORE_PRELOAD;
                    if (memoryReady) begin
                        if (wait_count == '0) next_state = S_FETCH_EXECUTE;
                        else                  next_wait  = wait_count - WAIT_WIDTH'(1);
                    end
                end
            end
            S_FETCH_EXECUTE: begin
                if (halt_request) begin
                    next_state   = S_HALT;
                    capture_halt = 1'b1;
                end else if ((is_load | is_store) & !memoryReady) begin
                    // Stall: keep the access request up but commit nothing.
                    memoryMode = is_load ? LOAD : STORE;
                end else begin
                    programCounterWriteEnable = 1'b1;
                    instructionAddressSource  = NEXT_PC;
                    if (is_load) begin
                        memoryMode    = LOAD;
                        rdWriteEnable = 1'b1;
                    end else if (is_store) begin
                        memoryMode    = STORE;
                    end else begin
                        rdWriteEnable = writes_rd;
                    end
                    next_state = is_multicycle ? S_EXECUTE : S_FETCH_EXECUTE;
                    next_wait  = entry_wait;
                end
            end
            S_HALT: ;
            default: next_state = S_INITIAL_FETCH;
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_INITIAL_FETCH;
            wait_count   <= '0;
            haltCause    <= 4'b0000;
            retiredCount <= '0;
        end else begin
            state      <= next_state;
            wait_count <= next_wait;
            if (capture_halt)
                haltCause <= haltCause | cause_bits;
            if ((state == S_FETCH_EXECUTE) && programCounterWriteEnable)
                retiredCount <= retiredCount + RETIRE_WIDTH'(1);
        end
    end

    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer plus hand sequences for halt, reset and wrap.
`timescale 1ns/1ps
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    localparam logic [6:0] LOADO  = 7'b0000011;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] STOREO = 7'b0100011;
    localparam logic [6:0] OPR    = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] ILLEG  = 7'b0000000;

    logic clock = 1'b0;
    logic reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic memoryReady, pc_mis, unaligned;

    logic rd_we, pc_we, halted;
    MemoryMode_t mem_mode;
    InstructionAddressSource_t ias;
    logic [3:0] cause;
    logic [7:0] count;

    logic rd_we0, pc_we0, halted0;
    MemoryMode_t mem_mode0;
    InstructionAddressSource_t ias0;
    logic [3:0] cause0;
    logic [7:0] count0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    control_sequencer #(
        .LOAD_LATENCY(3), .STORE_PRELOAD_LATENCY(1), .SW_SINGLE_CYCLE(1'b1),
        .WAIT_WIDTH(4), .RETIRE_WIDTH(8)
    ) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
        .memoryReady(memoryReady), .programCounterMisaligned(pc_mis),
        .memoryUnalignedAccess(unaligned), .rdWriteEnable(rd_we), .memoryMode(mem_mode),
        .programCounterWriteEnable(pc_we), .instructionAddressSource(ias),
        .halted(halted), .haltCause(cause), .retiredCount(count)
    );

    control_sequencer #(
        .LOAD_LATENCY(3), .STORE_PRELOAD_LATENCY(1), .SW_SINGLE_CYCLE(1'b0),
        .WAIT_WIDTH(4), .RETIRE_WIDTH(8)
    ) dut0 (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
        .memoryReady(memoryReady), .programCounterMisaligned(pc_mis),
        .memoryUnalignedAccess(unaligned), .rdWriteEnable(rd_we0), .memoryMode(mem_mode0),
        .programCounterWriteEnable(pc_we0), .instructionAddressSource(ias0),
        .halted(halted0), .haltCause(cause0), .retiredCount(count0)
    );

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       rdy, pm, ua;
        logic       rdwe;
        logic [1:0] mm;
        logic       pcwe, src, hlt;
        logic [7:0] cnt;
        logic [3:0] cz;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic rdy,
                                input logic pm, input logic ua, input logic rdwe,
                                input logic [1:0] mm, input logic pcwe, input logic src,
                                input logic hlt, input logic [7:0] cnt, input logic [3:0] cz);
        vec_t v;
        v.op = op; v.f3 = f3; v.rdy = rdy; v.pm = pm; v.ua = ua;
        v.rdwe = rdwe; v.mm = mm; v.pcwe = pcwe; v.src = src; v.hlt = hlt; v.cnt = cnt; v.cz = cz;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; state moves on the falling edge.
    task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic rdy,
                         input logic pm, input logic ua);
        @(posedge clock);
        #1;
        opcode = op; funct3 = f3; memoryReady = rdy; pc_mis = pm; unaligned = ua;
    endtask

    task automatic fall();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        opcode = OPIMM; funct3 = 3'b000; memoryReady = 1'b1; pc_mis = 1'b0; unaligned = 1'b0;
        fall();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(OPIMM,  3'd0, 1, 0, 0,  1, 2'd0, 1, 1, 0, 8'd0,  4'd0);
        vecs[1]  = mk(OPR,    3'd0, 1, 0, 0,  1, 2'd0, 1, 1, 0, 8'd1,  4'd0);
        vecs[2]  = mk(LUI,    3'd0, 1, 0, 0,  1, 2'd0, 1, 1, 0, 8'd2,  4'd0);
        vecs[3]  = mk(LOADO,  3'd2, 1, 0, 0,  0, 2'd1, 0, 0, 0, 8'd3,  4'd0);
        vecs[4]  = mk(LOADO,  3'd2, 1, 0, 0,  0, 2'd1, 0, 0, 0, 8'd3,  4'd0);
        vecs[5]  = mk(LOADO,  3'd2, 1, 0, 0,  0, 2'd1, 0, 0, 0, 8'd3,  4'd0);
        vecs[6]  = mk(LOADO,  3'd2, 1, 0, 0,  1, 2'd1, 1, 1, 0, 8'd3,  4'd0);
        vecs[7]  = mk(STOREO, 3'd0, 1, 0, 0,  0, 2'd2, 0, 0, 0, 8'd4,  4'd0);
        vecs[8]  = mk(STOREO, 3'd0, 0, 0, 0,  0, 2'd2, 0, 0, 0, 8'd4,  4'd0);
        vecs[9]  = mk(STOREO, 3'd0, 0, 0, 0,  0, 2'd2, 0, 0, 0, 8'd4,  4'd0);
        vecs[10] = mk(STOREO, 3'd0, 1, 0, 0,  0, 2'd3, 1, 1, 0, 8'd4,  4'd0);
        vecs[11] = mk(STOREO, 3'd2, 1, 0, 0,  0, 2'd3, 1, 1, 0, 8'd5,  4'd0);
        vecs[12] = mk(STOREO, 3'd2, 0, 0, 0,  0, 2'd3, 0, 0, 0, 8'd5,  4'd0);
        vecs[13] = mk(STOREO, 3'd2, 1, 0, 0,  0, 2'd3, 1, 1, 0, 8'd6,  4'd0);
        vecs[14] = mk(BRANCH, 3'd0, 1, 0, 0,  0, 2'd0, 1, 1, 0, 8'd7,  4'd0);
        vecs[15] = mk(JAL,    3'd0, 1, 0, 0,  1, 2'd0, 1, 1, 0, 8'd8,  4'd0);
        vecs[16] = mk(FENCE,  3'd0, 1, 0, 0,  0, 2'd0, 1, 1, 0, 8'd9,  4'd0);
        vecs[17] = mk(AUIPC,  3'd0, 1, 0, 0,  1, 2'd0, 1, 1, 0, 8'd10, 4'd0);
        vecs[18] = mk(JALR,   3'd0, 1, 0, 0,  1, 2'd0, 1, 1, 0, 8'd11, 4'd0);
        vecs[19] = mk(SYSTEM, 3'd0, 1, 0, 0,  0, 2'd0, 0, 0, 1, 8'd11, 4'd1);
        vecs[20] = mk(ILLEG,  3'd0, 1, 0, 0,  0, 2'd0, 0, 0, 1, 8'd11, 4'd1);
        vecs[21] = mk(OPIMM,  3'd0, 1, 1, 1,  0, 2'd0, 0, 0, 1, 8'd11, 4'd1);

        // Reset state, observed while reset is still asserted.
        reset = 1'b1;
        opcode = OPIMM; funct3 = 3'b000; memoryReady = 1'b1; pc_mis = 1'b0; unaligned = 1'b0;
        #3;
        check("reset rdWriteEnable", 32'(rd_we), 32'd0);
        check("reset pcWriteEnable", 32'(pc_we), 32'd0);
        check("reset memoryMode", 32'(mem_mode), 32'd0);
        check("reset addrSource", 32'(ias), 32'd0);
        check("reset halted", 32'(halted), 32'd0);
        check("reset haltCause", 32'(cause), 32'd0);
        check("reset retiredCount", 32'(count), 32'd0);
        fall();
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            apply(vecs[i].op, vecs[i].f3, vecs[i].rdy, vecs[i].pm, vecs[i].ua);
            fall();
            check($sformatf("row%0d rdWriteEnable", i), 32'(rd_we), 32'(vecs[i].rdwe));
            check($sformatf("row%0d memoryMode", i), 32'(mem_mode), 32'(vecs[i].mm));
            check($sformatf("row%0d pcWriteEnable", i), 32'(pc_we), 32'(vecs[i].pcwe));
            check($sformatf("row%0d addrSource", i), 32'(ias), 32'(vecs[i].src));
            check($sformatf("row%0d halted", i), 32'(halted), 32'(vecs[i].hlt));
            check($sformatf("row%0d retiredCount", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("row%0d haltCause", i), 32'(cause), 32'(vecs[i].cz));
        end

        // ecall: nothing commits in its own cycle, then HALT with cause 0001.
        do_reset();
        apply(OPIMM, 3'd0, 1, 0, 0); fall();
        apply(SYSTEM, 3'd0, 1, 0, 0);
        #1;
        check("ecall pcWriteEnable", 32'(pc_we), 32'd0);
        check("ecall rdWriteEnable", 32'(rd_we), 32'd0);
        check("ecall addrSource", 32'(ias), 32'd0);
        fall();
        check("ecall halted", 32'(halted), 32'd1);
        check("ecall haltCause", 32'(cause), 32'd1);
        check("ecall retiredCount", 32'(count), 32'd0);

        // Illegal opcode sets bit1.
        do_reset();
        apply(OPIMM, 3'd0, 1, 0, 0); fall();
        apply(ILLEG, 3'd0, 1, 0, 0); fall();
        check("illegal haltCause", 32'(cause), 32'd2);
        check("illegal halted", 32'(halted), 32'd1);

        // Misaligned PC with unaligned load and memory not ready: halt beats stall.
        do_reset();
        apply(OPIMM, 3'd0, 1, 0, 0); fall();
        apply(LOADO, 3'd2, 0, 1, 1);
        #1;
        check("misalign rdWriteEnable", 32'(rd_we), 32'd0);
        check("misalign pcWriteEnable", 32'(pc_we), 32'd0);
        check("misalign memoryMode", 32'(mem_mode), 32'd0);
        check("misalign addrSource", 32'(ias), 32'd0);
        fall();
        check("misalign halted", 32'(halted), 32'd1);
        check("misalign haltCause", 32'(cause), 32'hC);
        check("misalign retiredCount", 32'(count), 32'd0);

        // Asynchronous reset in the middle of a load's EXECUTE phase.
        do_reset();
        apply(OPIMM, 3'd0, 1, 0, 0); fall();
        apply(LOADO, 3'd2, 1, 0, 0); fall();
        check("midexec memoryMode", 32'(mem_mode), 32'd1);
        check("midexec retiredCount", 32'(count), 32'd1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async reset memoryMode", 32'(mem_mode), 32'd0);
        check("async reset rdWriteEnable", 32'(rd_we), 32'd0);
        check("async reset pcWriteEnable", 32'(pc_we), 32'd0);
        check("async reset retiredCount", 32'(count), 32'd0);
        fall();
        check("held reset pcWriteEnable", 32'(pc_we), 32'd0);
        reset = 1'b0;

        // sw: single cycle on dut, preload + store on dut0.
        do_reset();
        apply(OPIMM, 3'd0, 1, 0, 0); fall();
        apply(STOREO, 3'd2, 1, 0, 0); fall();
        check("sw single memoryMode", 32'(mem_mode), 32'd3);
        check("sw single pcWriteEnable", 32'(pc_we), 32'd1);
        check("sw preload memoryMode", 32'(mem_mode0), 32'd2);
        check("sw preload pcWriteEnable", 32'(pc_we0), 32'd0);
        apply(STOREO, 3'd2, 1, 0, 0); fall();
        check("sw final memoryMode", 32'(mem_mode0), 32'd3);
        check("sw final pcWriteEnable", 32'(pc_we0), 32'd1);
        check("sw final addrSource", 32'(ias0), 32'd1);

        // 8-bit retire counter wraps after 256 counted retirements.
        do_reset();
        for (int k = 0; k < 256; k++) begin
            apply(OPIMM, 3'd0, 1, 0, 0); fall();
        end
        check("wrap all-ones", 32'(count), 32'hFF);
        apply(OPR, 3'd0, 1, 0, 0); fall();
        check("wrap to zero", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised multicycle sequencing FSM for the JZJCoreF datapath, replacing the fixed one/two-cycle controller. Decides per instruction how many cycles it occupies, with configurable memory latency and a memory-ready stall. Captures the halt cause and counts retired instructions. Datapath selects (rd source, immediate mode, branch mode, opImm) stay in the decoder; this block drives only the sequencing controls.

## Interface
- LOAD_LATENCY, 1: EXECUTE cycles spent before the final cycle of a load (1..2^WAIT_WIDTH).
- STORE_PRELOAD_LATENCY, 1: EXECUTE cycles spent before the final cycle of sb/sh (1..2^WAIT_WIDTH).
- SW_SINGLE_CYCLE, 1: 1 = sw skips EXECUTE; 0 = every store uses the preload path.
- WAIT_WIDTH, 4: width of the latency down-counter.
- RETIRE_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  core clock; state registers update on the falling edge.
- reset  in  1  reset, asynchronous, active-high.
- opcode  in  7  current instruction opcode; changes on the rising edge.
- funct3  in  3  current instruction funct3.
- memoryReady  in  1  memory can complete the requested access this cycle.
- programCounterMisaligned  in  1  PC alignment error.
- memoryUnalignedAccess  in  1  unaligned data access; must not depend on memoryMode.
- rdWriteEnable  out  1  register file write.
- memoryMode  out  MemoryMode_t  NOP / LOAD / STORE_PRELOAD / STORE.
- programCounterWriteEnable  out  1  PC update.
- instructionAddressSource  out  InstructionAddressSource_t  CURRENT_PC / NEXT_PC.
- halted  out  1  state is HALT.
- haltCause  out  4  sticky: bit0 ecall/ebreak, bit1 illegal opcode, bit2 unaligned memory, bit3 PC misaligned.
- retiredCount  out  RETIRE_WIDTH  instructions completed since reset.

## Operation
- States: INITIAL_FETCH, FETCH_EXECUTE, EXECUTE, HALT (one-hot).
- Reset: state INITIAL_FETCH, wait counter 0, haltCause 0, retiredCount 0.
- Multicycle instructions:
  - Loads (0000011) always take the multicycle path.
  - Stores (0100011) take it when funct3 != 010 or SW_SINGLE_CYCLE = 0.
  - All other opcodes take one cycle.
- INITIAL_FETCH:
  - Drives all writes 0, memoryMode NOP, CURRENT_PC.
  - Next state is EXECUTE if the instruction is multicycle, otherwise FETCH_EXECUTE.
- EXECUTE:
  - Drives rdWriteEnable 0, PC write 0, CURRENT_PC.
  - memoryMode is LOAD for loads and STORE_PRELOAD for stores.
  - On entry the counter loads latency-1.
  - Each falling edge with memoryReady = 1, the counter decrements while nonzero.
  - At counter 0 with memoryReady = 1, next state is FETCH_EXECUTE.
  - memoryReady = 0 freezes the counter and the state.
- FETCH_EXECUTE default: PC write 1, NEXT_PC.
  - Loads: memoryMode LOAD, rdWriteEnable 1.
  - Stores: memoryMode STORE, rdWriteEnable 0.
  - lui/auipc/jal/jalr/OP/OP-IMM: rdWriteEnable 1.
  - Branch and fence: rdWriteEnable 0.
- Memory stall in FETCH_EXECUTE (load/store with memoryReady = 0):
  - rdWriteEnable 0 and PC write 0; memoryMode is held.
  - instructionAddressSource is CURRENT_PC; state is unchanged.
- ecall/ebreak (1110011) and illegal opcodes (none of the 11 valid opcodes) request a halt.
- Halt condition = misaligned PC | unaligned memory | ecall | illegal.
  - Evaluated in FETCH_EXECUTE and EXECUTE.
  - In the current cycle it forces rdWriteEnable 0, PC write 0, memoryMode NOP, CURRENT_PC.
  - Next state is HALT. Every asserted cause bit is ORed into haltCause on that edge.
- HALT:
  - Same outputs as INITIAL_FETCH, except instructionAddressSource is CURRENT_PC.
  - Never exits except by reset; haltCause is frozen.
- retiredCount increments on each falling edge where state is FETCH_EXECUTE, PC write = 1 and there is no halt condition. It wraps modulo 2^RETIRE_WIDTH; ecall and stalled cycles are not counted.

## Timing
- All outputs are combinational from state, counter, opcode, funct3, memoryReady and the error inputs.
- State, counter, haltCause and retiredCount update on the falling edge only; reset acts immediately.
- Latency with memoryReady held 1:
  - Single-cycle instruction: 1 cycle.
  - Load: LOAD_LATENCY+1 cycles.
  - sb/sh: STORE_PRELOAD_LATENCY+1 cycles.
  - sw: 1 cycle, or STORE_PRELOAD_LATENCY+1 when SW_SINGLE_CYCLE = 0.
- Each memoryReady-low cycle adds exactly one cycle.
- Reset asserted mid-EXECUTE or mid-stall returns to INITIAL_FETCH with no write asserted during reset.
- Halt and stall in the same cycle: halt wins.

## Test plan
- Reset, then addi, add, lui → one cycle each, rdWriteEnable 1, retiredCount 3, haltCause 0.
- LOAD_LATENCY=3, lw, memoryReady 1 → EXECUTE for 3 cycles with LOAD, then FETCH_EXECUTE with LOAD + rdWriteEnable; 4 cycles total, count +1.
- sb with memoryReady low for 2 cycles in EXECUTE → STORE_PRELOAD held 3 cycles, then STORE for 1 cycle; no PC write until the final cycle.
- sw with SW_SINGLE_CYCLE=1 → 1 cycle STORE; with SW_SINGLE_CYCLE=0 → STORE_PRELOAD then STORE.
- ecall → PC write 0, next state HALT, haltCause 0001, count unchanged; opcode 0000000 afterwards → haltCause remains 0001.
- Misaligned PC together with an unaligned load → haltCause 1100, all writes 0 that cycle. Then preload retiredCount to all-ones in an 8-bit build, retire one instruction → count wraps to 0.
